mp_core_initiator: RTL and testbench

- Per-core request master for the shared-memory request/response bus; the initiator end of the memory responder's req/gnt/rvalid interface.
- Accepts commands (single or burst read/write) from a core-side valid/ready port and drives the bus one beat at a time.
- Collects each rvalid response and returns it on a core-side response port, with a no-response timeout.
- One instance per core; multi-core arbitration sits outside this block.

---
 rtl/mp_core_initiator.sv | 217 +++++++++++++++++++++
 tb/tb_mp_core_initiator.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_core_initiator.sv
// mp_core_initiator: per-core request master for the shared-memory
// req/gnt/rvalid bus. Takes single or burst commands from the core, issues
// one bus beat at a time, and returns each response (or a timeout error) on
// the core-side response port.
// Optional build macro MP_INIT_STATS_EN: enables the saturating beat and
// timeout statistics counters. Without it, both stat outputs read as zero.
module mp_core_initiator #(
    parameter int         AW      = 11,
    parameter int         DW      = 8,
    parameter logic [1:0] CORE_ID = 2'd0,
    parameter int         TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    input  logic [2:0]    cmd_len,
    input  logic [31:0]   cmd_burst_id,
    output logic [1:0]    bus_core_id,
    output logic [3:0]    bus_opcode,
    output logic          bus_req,
    input  logic          bus_gnt,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    output logic [31:0]   bus_burst_id,
    input  logic          bus_rvalid,
    input  logic [DW-1:0] bus_rdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_last,
    output logic          rsp_err,
    output logic          busy,
    output logic [15:0]   stat_beats,
    output logic [7:0]    stat_timeouts
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_RSP_OUT  = 2'd3
    } state_t;

    // Last tmo value before the beat is declared lost.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t        state_r;
    state_t        state_next_s;
    logic          accept_s;
    logic          grant_s;
    logic          rsp_hit_s;
    logic          tmo_hit_s;
    logic          rsp_hs_s;

    logic          bus_we_r;
    logic [AW-1:0] bus_addr_r;
    logic [DW-1:0] bus_wdata_r;
    logic [3:0]    bus_opcode_r;
    logic [31:0]   bus_burst_id_r;
    logic [2:0]    beat_r;
    logic [7:0]    tmo_r;
    logic [DW-1:0] rsp_data_r;
    logic          rsp_last_r;
    logic          rsp_err_r;

    // State register; reset abandons any in-flight beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode and single-cycle event strobes.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        grant_s      = 1'b0;
        rsp_hit_s    = 1'b0;
        tmo_hit_s    = 1'b0;
        rsp_hs_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus_gnt) begin
                    grant_s      = 1'b1;
                    state_next_s = ST_WAIT_RSP;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_WAIT_RSP: begin
                // A response arriving on the timeout cycle still counts.
                if (bus_rvalid) begin
                    rsp_hit_s    = 1'b1;
                    state_next_s = ST_RSP_OUT;
                end else if (tmo_r == TMO_LAST) begin
                    tmo_hit_s    = 1'b1;
                    state_next_s = ST_RSP_OUT;
                end else begin
                    state_next_s = ST_WAIT_RSP;
                end
            end
            ST_RSP_OUT: begin
                if (rsp_ready) begin
                    rsp_hs_s     = 1'b1;
                    state_next_s = rsp_last_r ? ST_IDLE : ST_REQ;
                end else begin
                    state_next_s = ST_RSP_OUT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Command latch, per-beat address/data advance, timeout count and response capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus_we_r       <= 1'b0;
            bus_addr_r     <= '0;
            bus_wdata_r    <= '0;
            bus_opcode_r   <= 4'd0;
            bus_burst_id_r <= 32'd0;
            beat_r         <= 3'd0;
            tmo_r          <= 8'd0;
            rsp_data_r     <= '0;
            rsp_last_r     <= 1'b0;
            rsp_err_r      <= 1'b0;
        end else begin
            if (accept_s) begin
                bus_we_r       <= cmd_we;
                bus_addr_r     <= cmd_addr;
                bus_wdata_r    <= cmd_wdata;
                bus_opcode_r   <= {cmd_we, cmd_len};
                bus_burst_id_r <= cmd_burst_id;
                beat_r         <= 3'd0;
            end
            if (grant_s) begin
                tmo_r <= 8'd0;
            end else if (state_r == ST_WAIT_RSP) begin
                tmo_r <= tmo_r + 8'd1;
            end
            if (rsp_hit_s) begin
                rsp_data_r <= bus_rdata;
                rsp_err_r  <= 1'b0;
                rsp_last_r <= (beat_r == bus_opcode_r[2:0]);
            end else if (tmo_hit_s) begin
                // A lost beat aborts the rest of the burst.
                rsp_data_r <= '0;
                rsp_err_r  <= 1'b1;
                rsp_last_r <= 1'b1;
            end
            if (rsp_hs_s && !rsp_last_r) begin
                beat_r      <= beat_r + 3'd1;
                bus_addr_r  <= bus_addr_r + AW'(1);
                bus_wdata_r <= bus_wdata_r + DW'(1);
            end
        end
    end

`ifdef MP_INIT_STATS_EN
    logic [15:0] stat_beats_r;
    logic [7:0]  stat_timeouts_r;

    // Saturating counts of good response handshakes and timeout events.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_beats_r    <= 16'd0;
            stat_timeouts_r <= 8'd0;
        end else begin
            if (rsp_hs_s && !rsp_err_r && (stat_beats_r != 16'hFFFF)) begin
                stat_beats_r <= stat_beats_r + 16'd1;
            end
            if (tmo_hit_s && (stat_timeouts_r != 8'hFF)) begin
                stat_timeouts_r <= stat_timeouts_r + 8'd1;
            end
        end
    end

    assign stat_beats    = stat_beats_r;
    assign stat_timeouts = stat_timeouts_r;
`else
    assign stat_beats    = 16'd0;
    assign stat_timeouts = 8'd0;
`endif

    // cmd_ready is forced low while reset is held, even though the state reads IDLE.
    assign cmd_ready    = (state_r == ST_IDLE) && rst_n;
    assign bus_req      = (state_r == ST_REQ);
    assign rsp_valid    = (state_r == ST_RSP_OUT);
    assign busy         = (state_r != ST_IDLE);
    assign bus_core_id  = CORE_ID;
    assign bus_opcode   = bus_opcode_r;
    assign bus_we       = bus_we_r;
    assign bus_addr     = bus_addr_r;
    assign bus_wdata    = bus_wdata_r;
    assign bus_burst_id = bus_burst_id_r;
    assign rsp_data     = rsp_data_r;
    assign rsp_last     = rsp_last_r;
    assign rsp_err      = rsp_err_r;

endmodule

// File: tb/tb_mp_core_initiator.sv
// Self-checking bench for mp_core_initiator: table of command vectors with
// hand-computed per-beat expectations, driven against a small one-cycle
// memory responder, plus a hand-written reset-mid-burst sequence.
module tb_mp_core_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [10:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic [2:0]  cmd_len;
    logic [31:0] cmd_burst_id;
    logic [1:0]  bus_core_id;
    logic [3:0]  bus_opcode;
    logic        bus_req;
    logic        bus_gnt;
    logic        bus_we;
    logic [10:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic [31:0] bus_burst_id;
    logic        bus_rvalid;
    logic [7:0]  bus_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic        rsp_last;
    logic        rsp_err;
    logic        busy;
    logic [15:0] stat_beats;
    logic [7:0]  stat_timeouts;

    int total = 0;
    int bad   = 0;
    int ok_beats = 0;

    logic gnt_block = 1'b0;
    logic mute      = 1'b0;

    mp_core_initiator dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
        .cmd_burst_id(cmd_burst_id),
        .bus_core_id(bus_core_id), .bus_opcode(bus_opcode), .bus_req(bus_req),
        .bus_gnt(bus_gnt), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_burst_id(bus_burst_id),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .rsp_err(rsp_err), .busy(busy),
        .stat_beats(stat_beats), .stat_timeouts(stat_timeouts)
    );

    always #5 clk = ~clk;

    // Responder: grants immediately unless stalled, answers two edges after the grant.
    assign bus_gnt = bus_req && !gnt_block;
    logic [7:0] mem [0:2047];
    logic       p1_r;
    logic [7:0] p1_data_r;
    always @(posedge clk) begin
        if (!rst_n) begin
            p1_r       <= 1'b0;
            bus_rvalid <= 1'b0;
            bus_rdata  <= 8'h00;
        end else begin
            p1_r <= bus_req && bus_gnt && !mute;
            if (bus_req && bus_gnt) begin
                if (bus_we) begin
                    mem[bus_addr] <= bus_wdata;
                    p1_data_r     <= bus_wdata;
                end else begin
                    p1_data_r <= mem[bus_addr];
                end
            end
            bus_rvalid <= p1_r;
            bus_rdata  <= p1_data_r;
        end
    end

    typedef struct {
        logic            we;
        logic [10:0]     addr;
        logic [7:0]      wdata;
        logic [2:0]      len;
        logic [31:0]     tag;
        int              gstall;
        int              bp;
        logic            mute;
        int              nbeats;
        logic [3:0][10:0] e_addr;   // index 0 is the rightmost element
        logic [3:0][7:0]  e_wdata;
        logic [3:0][7:0]  e_rdata;
        logic            e_err;
    } vec_t;

    vec_t vecs [9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int t;
        int cyc;
        int req_cyc;
        t = 0;
        while (!cmd_ready && t < 100) begin step(); t++; end
        chk("cmd_ready_wait", cmd_ready, 1);
        gnt_block    = (v.gstall > 0);
        mute         = v.mute;
        cmd_valid    = 1'b1;
        cmd_we       = v.we;
        cmd_addr     = v.addr;
        cmd_wdata    = v.wdata;
        cmd_len      = v.len;
        cmd_burst_id = v.tag;
        step();
        cmd_valid = 1'b0;
        cyc = 1;
        for (int b = 0; b < v.nbeats; b++) begin
            t = 0;
            while (!bus_req && t < 100) begin step(); t++; cyc++; end
            chk("bus_req", bus_req, 1);
            req_cyc = cyc;
            if (b == 0) begin
                chk("req_latency", cyc, 1);
                chk("bus_opcode", bus_opcode, {v.we, v.len});
                chk("bus_burst_id", bus_burst_id, v.tag);
                chk("bus_core_id", bus_core_id, 2'd0);
            end
            chk("bus_addr", bus_addr, v.e_addr[b]);
            chk("bus_wdata", bus_wdata, v.e_wdata[b]);
            chk("bus_we", bus_we, v.we);
            if (b == 0 && v.gstall > 0) begin
                for (int i = 0; i < v.gstall; i++) begin
                    chk("stall_req", bus_req, 1);
                    chk("stall_addr", bus_addr, v.e_addr[b]);
                    chk("stall_wdata", bus_wdata, v.e_wdata[b]);
                    chk("stall_no_rsp", rsp_valid, 0);
                    step(); cyc++;
                end
                gnt_block = 1'b0;
            end
            t = 0;
            while (!rsp_valid && t < 100) begin step(); t++; cyc++; end
            chk("rsp_valid", rsp_valid, 1);
            if (b == 0 && v.gstall == 0 && !v.mute) begin
                chk("rsp_latency", cyc, 4);
            end
            if (v.mute) begin
                chk("timeout_cycles", cyc - req_cyc, 16);
            end
            chk("rsp_data", rsp_data, v.e_rdata[b]);
            chk("rsp_err", rsp_err, v.e_err);
            chk("rsp_last", rsp_last, (v.e_err || b == v.nbeats - 1));
            if (b == 0 && v.bp > 0) begin
                rsp_ready = 1'b0;
                for (int i = 0; i < v.bp; i++) begin
                    step();
                    chk("bp_valid", rsp_valid, 1);
                    chk("bp_data", rsp_data, v.e_rdata[b]);
                    chk("bp_last", rsp_last, (v.e_err || b == v.nbeats - 1));
                    chk("bp_err", rsp_err, v.e_err);
                    chk("bp_no_req", bus_req, 0);
                end
                rsp_ready = 1'b1;
            end
            if (!v.e_err) ok_beats++;
            step(); cyc++;
        end
        chk("ready_after_last", cmd_ready, 1);
        chk("idle_after_last", busy, 0);
        mute = 1'b0;
    endtask

    initial begin
        int t;
        vecs[0] = '{we:1'b1, addr:11'h010, wdata:8'hA5, len:3'd0, tag:32'hCAFE_0000,
                    gstall:0, bp:0, mute:1'b0, nbeats:1,
                    e_addr:{11'h0, 11'h0, 11'h0, 11'h010}, e_wdata:{8'h0, 8'h0, 8'h0, 8'hA5},
                    e_rdata:{8'h0, 8'h0, 8'h0, 8'hA5}, e_err:1'b0};
        vecs[1] = '{we:1'b0, addr:11'h010, wdata:8'h00, len:3'd0, tag:32'hCAFE_0001,
                    gstall:0, bp:0, mute:1'b0, nbeats:1,
                    e_addr:{11'h0, 11'h0, 11'h0, 11'h010}, e_wdata:{8'h0, 8'h0, 8'h0, 8'h00},
                    e_rdata:{8'h0, 8'h0, 8'h0, 8'hA5}, e_err:1'b0};
        vecs[2] = '{we:1'b1, addr:11'h7FE, wdata:8'h10, len:3'd3, tag:32'hCAFE_0002,
                    gstall:0, bp:0, mute:1'b0, nbeats:4,
                    e_addr:{11'h001, 11'h000, 11'h7FF, 11'h7FE}, e_wdata:{8'h13, 8'h12, 8'h11, 8'h10},
                    e_rdata:{8'h13, 8'h12, 8'h11, 8'h10}, e_err:1'b0};
        vecs[3] = '{we:1'b0, addr:11'h7FE, wdata:8'h00, len:3'd3, tag:32'hCAFE_0003,
                    gstall:0, bp:0, mute:1'b0, nbeats:4,
                    e_addr:{11'h001, 11'h000, 11'h7FF, 11'h7FE}, e_wdata:{8'h03, 8'h02, 8'h01, 8'h00},
                    e_rdata:{8'h13, 8'h12, 8'h11, 8'h10}, e_err:1'b0};
        vecs[4] = '{we:1'b0, addr:11'h000, wdata:8'h80, len:3'd1, tag:32'hCAFE_0004,
                    gstall:0, bp:0, mute:1'b0, nbeats:2,
                    e_addr:{11'h0, 11'h0, 11'h001, 11'h000}, e_wdata:{8'h0, 8'h0, 8'h81, 8'h80},
                    e_rdata:{8'h0, 8'h0, 8'h13, 8'h12}, e_err:1'b0};
        vecs[5] = '{we:1'b0, addr:11'h020, wdata:8'h00, len:3'd3, tag:32'hCAFE_0005,
                    gstall:0, bp:0, mute:1'b1, nbeats:1,
                    e_addr:{11'h0, 11'h0, 11'h0, 11'h020}, e_wdata:{8'h0, 8'h0, 8'h0, 8'h00},
                    e_rdata:{8'h0, 8'h0, 8'h0, 8'h00}, e_err:1'b1};
        vecs[6] = '{we:1'b1, addr:11'h123, wdata:8'h5C, len:3'd0, tag:32'hCAFE_0006,
                    gstall:5, bp:0, mute:1'b0, nbeats:1,
                    e_addr:{11'h0, 11'h0, 11'h0, 11'h123}, e_wdata:{8'h0, 8'h0, 8'h0, 8'h5C},
                    e_rdata:{8'h0, 8'h0, 8'h0, 8'h5C}, e_err:1'b0};
        vecs[7] = '{we:1'b0, addr:11'h123, wdata:8'h00, len:3'd0, tag:32'hCAFE_0007,
                    gstall:0, bp:3, mute:1'b0, nbeats:1,
                    e_addr:{11'h0, 11'h0, 11'h0, 11'h123}, e_wdata:{8'h0, 8'h0, 8'h0, 8'h00},
                    e_rdata:{8'h0, 8'h0, 8'h0, 8'h5C}, e_err:1'b0};
        vecs[8] = '{we:1'b1, addr:11'h050, wdata:8'h3C, len:3'd0, tag:32'hCAFE_0008,
                    gstall:0, bp:0, mute:1'b0, nbeats:1,
                    e_addr:{11'h0, 11'h0, 11'h0, 11'h050}, e_wdata:{8'h0, 8'h0, 8'h0, 8'h3C},
                    e_rdata:{8'h0, 8'h0, 8'h0, 8'h3C}, e_err:1'b0};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 11'h000;
        cmd_wdata = 8'h00; cmd_len = 3'd0; cmd_burst_id = 32'd0; rsp_ready = 1'b1;
        step(); step();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bus_addr", bus_addr, 11'h000);
        chk("rst_rsp_data", rsp_data, 8'h00);
        chk("rst_core_id", bus_core_id, 2'd0);
        chk("rst_stat_beats", stat_beats, 16'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_cmd_ready", cmd_ready, 1);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

`ifdef MP_INIT_STATS_EN
        chk("stat_beats", stat_beats, ok_beats);
        chk("stat_timeouts", stat_timeouts, 8'd1);
`else
        chk("stat_beats_off", stat_beats, 16'd0);
        chk("stat_timeouts_off", stat_timeouts, 8'd0);
`endif

        // Reset during beat 2 of a 4-beat read burst.
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 11'h7FE; cmd_wdata = 8'h00;
        cmd_len = 3'd3; cmd_burst_id = 32'hDEAD_0001;
        step();
        cmd_valid = 1'b0;
        t = 0;
        while (!(bus_req && bus_addr == 11'h000) && t < 100) begin step(); t++; end
        chk("mid_burst_reached", bus_addr, 11'h000);
        rst_n = 1'b0;
        step();
        chk("mid_rst_bus_req", bus_req, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        chk("mid_rst_opcode", bus_opcode, 4'd0);
        chk("mid_rst_stat_beats", stat_beats, 16'd0);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_ready_after", cmd_ready, 1);
        ok_beats = 0;
        run_vec(vecs[8]);
`ifdef MP_INIT_STATS_EN
        chk("stat_beats_after_rst", stat_beats, ok_beats);
        chk("stat_timeouts_after_rst", stat_timeouts, 8'd0);
`else
        chk("stat_beats_after_rst_off", stat_beats, 16'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
